// File: rtl/evm_pkg.sv
// Shared types and constants for the ballot front-end: controller states,
// reject codes and the common ID bus width.
package evm_pkg;

   localparam int ID_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      CAST,
      HOLD,
      CLOSED
   } state_t;

   localparam logic [1:0] REJ_TIMEOUT     = 2'd0;
   localparam logic [1:0] REJ_BAD_VOTER   = 2'd1;
   localparam logic [1:0] REJ_DOUBLE_VOTE = 2'd2;
   localparam logic [1:0] REJ_BAD_CAND    = 2'd3;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus registered rising-edge detect.
// The one-cycle pulse appears three clocks after the button rises; a held button gives one pulse.
module btn_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic [2:0] sync_reg;
   logic       pulse_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg  <= '0;
         pulse_reg <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[1:0], btn};
         pulse_reg <= sync_reg[1] & ~sync_reg[2];
      end
   end

   assign pulse = pulse_reg;

endmodule

// File: rtl/ballot_controller.sv
// Voting front-end: conditions buttons, authenticates voters, blocks double votes,
// times out idle sessions and emits one vote_cast pulse per accepted ballot.
module ballot_controller
   import evm_pkg::*;
#(
   parameter int NUM_VOTERS     = 4,
   parameter int NUM_CANDIDATES = 3,
   parameter int ID_W           = evm_pkg::ID_W,
   parameter int TIMEOUT_CYC    = 1000,
   parameter int COOLDOWN_CYC   = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ID_W-1:0]                 voter_id_in,
   input  logic [ID_W-1:0]                 candidate_in,
   input  logic                            id_load,
   input  logic                            vote_btn,
   input  logic                            close_poll,
   output logic [ID_W-1:0]                 voter_id,
   output logic [ID_W-1:0]                 candidate_number,
   output logic                            vote_cast,
   output logic                            busy,
   output logic                            reject,
   output logic [1:0]                      reject_code,
   output logic                            poll_closed,
   output logic [$clog2(NUM_VOTERS+1)-1:0] ballots
);

   localparam int BAL_W  = $clog2(NUM_VOTERS + 1);
   localparam int VIDX_W = (NUM_VOTERS > 1) ? $clog2(NUM_VOTERS) : 1;
   localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int HOLD_W = $clog2(COOLDOWN_CYC + 1);

   localparam logic [ID_W:0]   NV_LIM = (ID_W + 1)'(NUM_VOTERS);
   localparam logic [ID_W:0]   NC_LIM = (ID_W + 1)'(NUM_CANDIDATES);
   localparam logic [TMR_W-1:0]  T_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [HOLD_W-1:0] H_LAST = HOLD_W'(COOLDOWN_CYC - 1);

   // Button order on the edge bus: 0=id_load, 1=vote_btn, 2=close_poll
   logic [2:0] btn_raw;
   logic [2:0] btn_edge;

   assign btn_raw = {close_poll, vote_btn, id_load};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         btn_sync_edge u_btn (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[gi]),
            .pulse (btn_edge[gi])
         );
      end
   endgenerate

   logic id_edge, vote_edge, close_edge;
   assign id_edge    = btn_edge[0];
   assign vote_edge  = btn_edge[1];
   assign close_edge = btn_edge[2];

   state_t                  state_reg, state_next;
   logic [TMR_W-1:0]        timer_reg, timer_next;
   logic [HOLD_W-1:0]       hold_reg, hold_next;
   logic [NUM_VOTERS-1:0]   voted_reg, voted_next;
   logic [BAL_W-1:0]        ballots_reg, ballots_next;
   logic [ID_W-1:0]         voter_id_reg, voter_id_next;
   logic [ID_W-1:0]         cand_reg, cand_next;
   logic                    reject_reg, reject_next;
   logic [1:0]              code_reg, code_next;
   logic                    close_pend_reg, close_pend_next;

   logic id_ok, cand_ok;
   assign id_ok   = {1'b0, voter_id_in}  < NV_LIM;
   assign cand_ok = {1'b0, candidate_in} < NC_LIM;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         timer_reg      <= '0;
         hold_reg       <= '0;
         voted_reg      <= '0;
         ballots_reg    <= '0;
         voter_id_reg   <= '0;
         cand_reg       <= '0;
         reject_reg     <= 1'b0;
         code_reg       <= '0;
         close_pend_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         hold_reg       <= hold_next;
         voted_reg      <= voted_next;
         ballots_reg    <= ballots_next;
         voter_id_reg   <= voter_id_next;
         cand_reg       <= cand_next;
         reject_reg     <= reject_next;
         code_reg       <= code_next;
         close_pend_reg <= close_pend_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      timer_next      = timer_reg;
      hold_next       = hold_reg;
      voted_next      = voted_reg;
      ballots_next    = ballots_reg;
      voter_id_next   = voter_id_reg;
      cand_next       = cand_reg;
      reject_next     = 1'b0;
      code_next       = code_reg;
      close_pend_next = close_pend_reg;

      case (state_reg)
         IDLE: begin
            if (close_edge) begin
               state_next = CLOSED;
            end else if (id_edge) begin
               if (!id_ok) begin
                  reject_next = 1'b1;
                  code_next   = REJ_BAD_VOTER;
               end else if (voted_reg[voter_id_in[VIDX_W-1:0]]) begin
                  reject_next = 1'b1;
                  code_next   = REJ_DOUBLE_VOTE;
               end else begin
                  voter_id_next = voter_id_in;
                  timer_next    = '0;
                  state_next    = SELECT;
               end
            end
         end

         SELECT: begin
            // A valid vote on the last cycle still wins over the timeout
            if (close_edge) begin
               state_next = CLOSED;
            end else if (vote_edge && cand_ok) begin
               cand_next  = candidate_in;
               state_next = CAST;
            end else if (timer_reg == T_LAST) begin
               reject_next = 1'b1;
               code_next   = REJ_TIMEOUT;
               state_next  = IDLE;
            end else begin
               if (vote_edge) begin
                  reject_next = 1'b1;
                  code_next   = REJ_BAD_CAND;
               end
               timer_next = timer_reg + TMR_W'(1);
            end
         end

         CAST: begin
            voted_next[voter_id_reg[VIDX_W-1:0]] = 1'b1;
            ballots_next = ballots_reg + BAL_W'(1);
            hold_next    = '0;
            state_next   = HOLD;
            if (close_edge) close_pend_next = 1'b1;
         end

         HOLD: begin
            if (hold_reg == H_LAST) begin
               state_next = (close_pend_reg || close_edge) ? CLOSED : IDLE;
            end else begin
               hold_next = hold_reg + HOLD_W'(1);
               if (close_edge) close_pend_next = 1'b1;
            end
         end

         CLOSED: state_next = CLOSED;

         default: state_next = IDLE;
      endcase
   end

   assign voter_id         = voter_id_reg;
   assign candidate_number = cand_reg;
   assign vote_cast        = (state_reg == CAST);
   assign busy             = (state_reg == SELECT) || (state_reg == CAST) || (state_reg == HOLD);
   assign reject           = reject_reg;
   assign reject_code      = code_reg;
   assign poll_closed      = (state_reg == CLOSED);
   assign ballots          = ballots_reg;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller: an event-level model predicts every output each
// cycle, and literal checks after each scenario pin the expected totals and codes.
module tb_ballot_controller;

   localparam int NV   = 4;
   localparam int NC   = 3;
   localparam int IDW  = 4;
   localparam int TO   = 1000;
   localparam int COOL = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [IDW-1:0] voter_id_in = '0;
   logic [IDW-1:0] candidate_in = '0;
   logic           id_load = 1'b0;
   logic           vote_btn = 1'b0;
   logic           close_poll = 1'b0;
   logic [IDW-1:0] voter_id;
   logic [IDW-1:0] candidate_number;
   logic           vote_cast;
   logic           busy;
   logic           reject;
   logic [1:0]     reject_code;
   logic           poll_closed;
   logic [2:0]     ballots;

   ballot_controller #(
      .NUM_VOTERS     (NV),
      .NUM_CANDIDATES (NC),
      .ID_W           (IDW),
      .TIMEOUT_CYC    (TO),
      .COOLDOWN_CYC   (COOL)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .voter_id_in      (voter_id_in),
      .candidate_in     (candidate_in),
      .id_load          (id_load),
      .vote_btn         (vote_btn),
      .close_poll       (close_poll),
      .voter_id         (voter_id),
      .candidate_number (candidate_number),
      .vote_cast        (vote_cast),
      .busy             (busy),
      .reject           (reject),
      .reject_code      (reject_code),
      .poll_closed      (poll_closed),
      .ballots          (ballots)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_cast_seen = 0;

   // Behavioural model: a button counts once, three clocks after its rise is first sampled.
   bit [3:0] h_id, h_vote, h_close;
   int  m_vid, m_cand, m_code, m_ballots, m_age, m_cool;
   bit  m_cast, m_rej, m_closed, m_casting, m_pend;
   bit  m_voted [NV];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_id = '0; h_vote = '0; h_close = '0;
         m_vid = 0; m_cand = 0; m_code = 0; m_ballots = 0; m_age = -1; m_cool = 0;
         m_cast = 0; m_rej = 0; m_closed = 0; m_casting = 0; m_pend = 0;
         for (int i = 0; i < NV; i++) m_voted[i] = 0;
      end else begin
         bit ev_id, ev_vote, ev_close;
         ev_id    = h_id[2] & ~h_id[3];
         ev_vote  = h_vote[2] & ~h_vote[3];
         ev_close = h_close[2] & ~h_close[3];
         h_id    = {h_id[2:0], id_load};
         h_vote  = {h_vote[2:0], vote_btn};
         h_close = {h_close[2:0], close_poll};
         m_rej = 0;
         if (m_closed) begin
         end else if (m_casting) begin
            if (ev_close) m_pend = 1;
            m_voted[m_vid] = 1;
            m_ballots++;
            m_casting = 0;
            m_cool = COOL;
         end else if (m_cool > 0) begin
            if (ev_close) m_pend = 1;
            m_cool--;
            if (m_cool == 0 && m_pend) m_closed = 1;
         end else if (m_age >= 0) begin
            if (ev_close) begin
               m_age = -1; m_closed = 1;
            end else if (ev_vote && int'(candidate_in) < NC) begin
               m_cand = int'(candidate_in); m_age = -1; m_casting = 1;
            end else if (m_age == TO - 1) begin
               m_rej = 1; m_code = 0; m_age = -1;
            end else begin
               if (ev_vote) begin m_rej = 1; m_code = 3; end
               m_age++;
            end
         end else begin
            if (ev_close) m_closed = 1;
            else if (ev_id) begin
               if (int'(voter_id_in) >= NV) begin m_rej = 1; m_code = 1; end
               else if (m_voted[voter_id_in]) begin m_rej = 1; m_code = 2; end
               else begin m_vid = int'(voter_id_in); m_age = 0; end
            end
         end
         m_cast = m_casting;
      end
   end

   task automatic flag(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         bit m_busy;
         m_busy = (m_age >= 0) || m_casting || (m_cool > 0);
         if (vote_cast) n_cast_seen++;
         flag("vote_cast", int'(vote_cast), int'(m_cast));
         flag("reject", int'(reject), int'(m_rej));
         flag("reject_code", int'(reject_code), m_code);
         flag("busy", int'(busy), int'(m_busy));
         flag("poll_closed", int'(poll_closed), int'(m_closed));
         flag("ballots", int'(ballots), m_ballots);
         flag("voter_id", int'(voter_id), m_vid);
         flag("candidate_number", int'(candidate_number), m_cand);
         if (vote_cast && reject) flag("cast_and_reject", 1, 0);
      end
   end

   task automatic press_id(input int v);
      @(negedge clk);
      voter_id_in = IDW'(v);
      id_load = 1'b1;
      repeat (5) @(negedge clk);
      id_load = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic press_vote(input int c);
      @(negedge clk);
      candidate_in = IDW'(c);
      vote_btn = 1'b1;
      repeat (5) @(negedge clk);
      vote_btn = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic wait_free(input string nm);
      int n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      flag(nm, int'(busy), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      flag("reset_ballots", int'(ballots), 0);
      flag("reset_busy", int'(busy), 0);
      flag("reset_closed", int'(poll_closed), 0);
      flag("reset_voter_id", int'(voter_id), 0);

      // 1: normal ballot
      press_id(2);
      flag("t1_busy_select", int'(busy), 1);
      press_vote(1);
      wait_free("t1_free");
      flag("t1_ballots", int'(ballots), 1);
      flag("t1_voter", int'(voter_id), 2);
      flag("t1_cand", int'(candidate_number), 1);
      flag("t1_casts", n_cast_seen, 1);

      // 2: double vote
      press_id(2);
      flag("t2_code", int'(reject_code), 2);
      flag("t2_busy", int'(busy), 0);
      flag("t2_casts", n_cast_seen, 1);

      // 3: bad voter, bad candidate, then good candidate
      press_id(7);
      flag("t3_code_voter", int'(reject_code), 1);
      press_id(0);
      press_vote(5);
      flag("t3_code_cand", int'(reject_code), 3);
      flag("t3_still_select", int'(busy), 1);
      press_vote(0);
      wait_free("t3_free");
      flag("t3_ballots", int'(ballots), 2);
      flag("t3_voter", int'(voter_id), 0);
      flag("t3_cand", int'(candidate_number), 0);

      // 4: timeout, voter stays unmarked
      press_id(1);
      flag("t4_busy", int'(busy), 1);
      repeat (TO) @(negedge clk);
      flag("t4_timeout_idle", int'(busy), 0);
      flag("t4_code", int'(reject_code), 0);
      flag("t4_ballots", int'(ballots), 2);
      press_id(1);
      press_vote(2);
      wait_free("t4_free");
      flag("t4_ballots_after", int'(ballots), 3);
      flag("t4_voter", int'(voter_id), 1);

      // 5: close arrives during HOLD
      press_id(3);
      @(negedge clk);
      candidate_in = IDW'(2);
      vote_btn = 1'b1;
      repeat (3) @(negedge clk);
      close_poll = 1'b1;
      repeat (5) @(negedge clk);
      vote_btn = 1'b0;
      close_poll = 1'b0;
      wait_free("t5_free");
      repeat (2) @(negedge clk);
      flag("t5_closed", int'(poll_closed), 1);
      flag("t5_ballots", int'(ballots), 4);
      flag("t5_casts", n_cast_seen, 4);
      press_id(0);
      press_vote(1);
      flag("t5_no_cast", n_cast_seen, 4);
      flag("t5_voter_hold", int'(voter_id), 3);
      flag("t5_cand_hold", int'(candidate_number), 2);

      // 6: reset mid-SELECT
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      flag("t6_open", int'(poll_closed), 0);
      press_id(2);
      flag("t6_select", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      flag("t6_async_busy", int'(busy), 0);
      flag("t6_async_ballots", int'(ballots), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      press_id(2);
      press_vote(1);
      wait_free("t6_free");
      flag("t6_ballots", int'(ballots), 1);
      flag("t6_voter", int'(voter_id), 2);
      flag("t6_cand", int'(candidate_number), 1);
      flag("t6_casts", n_cast_seen, 5);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
